// File: rtl/parking_pkg.sv
// Shared definitions for the parking gate keypad: FSM encoding, special key codes and the
// idle value of the pass code bus.
package parking_pkg;

   // One-hot state encoding of the keypad entry sequencer.
   typedef enum logic [6:0] {
      StIdle       = 7'b0000001,
      StWaitD1     = 7'b0000010,
      StWaitD2     = 7'b0000100,
      StReady      = 7'b0001000,
      StSend       = 7'b0010000,
      StWaitResult = 7'b0100000,
      StDone       = 7'b1000000
   } state_e;

   localparam logic [3:0] KEY_CLEAR = 4'hA;
   localparam logic [3:0] KEY_ENTER = 4'hB;

   // Non-BCD, so it can never match a stored PIN.
   localparam logic [7:0] PASS_IDLE_DEFAULT = 8'hFF;

   function automatic logic is_digit(input logic [3:0] code);
      return code <= 4'd9;
   endfunction

endpackage

// File: rtl/entry_timer.sv
// Saturating cycle counter shared by the digit-entry timeout and the result wait.
// Cleared by the owner on every restart event; expired is raised while the count sits at or
// beyond the loaded last-cycle value.
module entry_timer #(
   parameter int unsigned WIDTH = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic [WIDTH-1:0] last,
   output logic             expired
);

   logic [WIDTH-1:0] count_q;

   // Count cycles since the last clear; hold at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (clr) begin
         count_q <= '0;
      end else if (count_q != {WIDTH{1'b1}}) begin
         count_q <= count_q + WIDTH'(1);
      end
   end

   assign expired = (count_q >= last);

endmodule

// File: rtl/pin_entry_keypad.sv
// Keypad-side PIN transmitter: collects two BCD digits while a car waits at the entry sensor,
// sends them as {hi,lo} with a one-cycle strobe and follows the manager's verdict.
module pin_entry_keypad
   import parking_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1000,
   parameter int unsigned RESULT_CYCLES  = 8,
   parameter logic [7:0]  PASS_IDLE      = PASS_IDLE_DEFAULT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sensorA,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   input  logic       gateState,
   input  logic       wrongPinAlarm,
   output logic [7:0] pass,
   output logic       pass_valid,
   output logic       entry_busy,
   output logic [1:0] digit_count,
   output logic [1:0] attempts
);

   localparam int unsigned MAX_CYCLES = (TIMEOUT_CYCLES > RESULT_CYCLES) ?
                                        TIMEOUT_CYCLES : RESULT_CYCLES;
   localparam int unsigned TIMER_W    = $clog2(MAX_CYCLES + 1);
   // The timer reads 0 in the first cycle after a restart, so the Nth cycle shows N-1.
   localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TIMER_W-1:0] RESULT_LAST  = TIMER_W'(RESULT_CYCLES - 1);

   state_e       state_q, state_d;
   logic [3:0]   hi_q, hi_d, lo_q, lo_d;
   logic [7:0]   pass_q, pass_d;
   logic         pv_q, pv_d;
   logic         busy_q, busy_d;
   logic [1:0]   dc_q, dc_d;
   logic [1:0]   att_q, att_d;
   logic         key_taken;
   logic         timer_clr;
   logic         timer_expired;
   logic [TIMER_W-1:0] timer_last;
   logic         key_digit, key_clear, key_enter;
   logic         abort, timeout;

   assign key_digit = key_valid && is_digit(key_code);
   assign key_clear = key_valid && (key_code == KEY_CLEAR);
   assign key_enter = key_valid && (key_code == KEY_ENTER);

   assign timer_last = (state_q == StWaitResult) ? RESULT_LAST : TIMEOUT_LAST;

   entry_timer #(
      .WIDTH (TIMER_W)
   ) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (timer_clr),
      .last    (timer_last),
      .expired (timer_expired)
   );

   // Next-state and registered-output values; abort beats timeout beats key handling.
   always_comb begin
      state_d   = state_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      pass_d    = pass_q;
      pv_d      = 1'b0;
      dc_d      = dc_q;
      att_d     = att_q;
      key_taken = 1'b0;
      abort     = !sensorA && (state_q != StIdle) && (state_q != StDone);
      timeout   = timer_expired && ((state_q == StWaitD2) || (state_q == StReady));

      if (abort) begin
         state_d = StIdle;
         hi_d    = '0;
         lo_d    = '0;
         pass_d  = PASS_IDLE;
         dc_d    = 2'd0;
         att_d   = 2'd0;
      end else if (timeout) begin
         state_d = StWaitD1;
         dc_d    = 2'd0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (sensorA) state_d = StWaitD1;
            end
            StWaitD1: begin
               if (key_digit) begin
                  hi_d      = key_code;
                  dc_d      = 2'd1;
                  state_d   = StWaitD2;
                  key_taken = 1'b1;
               end
            end
            StWaitD2: begin
               if (key_digit) begin
                  lo_d      = key_code;
                  dc_d      = 2'd2;
                  state_d   = StReady;
                  key_taken = 1'b1;
               end else if (key_clear) begin
                  dc_d      = 2'd0;
                  state_d   = StWaitD1;
                  key_taken = 1'b1;
               end
            end
            StReady: begin
               if (key_enter) begin
                  state_d   = StSend;
                  key_taken = 1'b1;
               end else if (key_clear) begin
                  dc_d      = 2'd0;
                  state_d   = StWaitD1;
                  key_taken = 1'b1;
               end
            end
            StSend: begin
               pass_d  = {hi_q, lo_q};
               pv_d    = 1'b1;
               att_d   = (att_q == 2'd3) ? 2'd3 : att_q + 2'd1;
               state_d = StWaitResult;
            end
            StWaitResult: begin
               if (gateState) begin
                  state_d = StDone;
                  att_d   = 2'd0;
                  pass_d  = PASS_IDLE;
               end else if (wrongPinAlarm || timer_expired) begin
                  state_d = StWaitD1;
                  pass_d  = PASS_IDLE;
                  dc_d    = 2'd0;
               end
            end
            StDone: begin
               pass_d = PASS_IDLE;
               if (!sensorA) begin
                  state_d = StIdle;
                  dc_d    = 2'd0;
               end
            end
            default: begin
               state_d = StIdle;
               pass_d  = PASS_IDLE;
               dc_d    = 2'd0;
               att_d   = 2'd0;
            end
         endcase
      end

      busy_d    = (state_d != StIdle) && (state_d != StDone);
      timer_clr = key_taken || (state_d != state_q);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         hi_q    <= '0;
         lo_q    <= '0;
         pass_q  <= PASS_IDLE;
         pv_q    <= 1'b0;
         busy_q  <= 1'b0;
         dc_q    <= 2'd0;
         att_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         pass_q  <= pass_d;
         pv_q    <= pv_d;
         busy_q  <= busy_d;
         dc_q    <= dc_d;
         att_q   <= att_d;
      end
   end

   assign pass        = pass_q;
   assign pass_valid  = pv_q;
   assign entry_busy  = busy_q;
   assign digit_count = dc_q;
   assign attempts    = att_q;

endmodule

// File: tb/tb_pin_entry_keypad.sv
// Bench for pin_entry_keypad: directed scenarios plus a random soak, all checked against a
// transaction-level model of the keypad (held digits as a queue, a coarse phase, an age count).
module tb_pin_entry_keypad;

   localparam int T = 1000;
   localparam int R = 8;
   localparam logic [13:0] RESET_VEC = {8'hFF, 1'b0, 1'b0, 2'd0, 2'd0};

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sensorA = 1'b0;
   logic       key_valid = 1'b0;
   logic [3:0] key_code = 4'h0;
   logic       gateState = 1'b0;
   logic       wrongPinAlarm = 1'b0;
   logic [7:0] pass;
   logic       pass_valid, entry_busy;
   logic [1:0] digit_count, attempts;
   logic [13:0] obs;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pin_entry_keypad #(
      .TIMEOUT_CYCLES (T),
      .RESULT_CYCLES  (R),
      .PASS_IDLE      (8'hFF)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .sensorA       (sensorA),
      .key_valid     (key_valid),
      .key_code      (key_code),
      .gateState     (gateState),
      .wrongPinAlarm (wrongPinAlarm),
      .pass          (pass),
      .pass_valid    (pass_valid),
      .entry_busy    (entry_busy),
      .digit_count   (digit_count),
      .attempts      (attempts)
   );

   assign obs = {pass, pass_valid, entry_busy, digit_count, attempts};

   // ---------------- reference model ----------------
   typedef enum {MIdle, MCollect, MSend, MResult, MDone} mphase_e;
   mphase_e m_phase;
   int      m_digits[$];
   int      m_pass, m_att, m_age;
   bit      m_pv;

   function automatic void model_reset();
      m_phase = MIdle;
      m_digits.delete();
      m_pass = 255;
      m_att  = 0;
      m_pv   = 0;
      m_age  = 1;
   endfunction

   // Advance the model across one clock edge using the inputs currently applied.
   function automatic void model_step();
      bit restart;
      bit busy;
      restart = 0;
      busy = (m_phase == MCollect) || (m_phase == MSend) || (m_phase == MResult);
      m_pv = 0;
      if (busy && !sensorA) begin
         m_phase = MIdle;
         m_digits.delete();
         m_pass = 255;
         m_att = 0;
         restart = 1;
      end else if (m_phase == MCollect && m_digits.size() > 0 && m_age >= T) begin
         m_digits.delete();
         restart = 1;
      end else begin
         case (m_phase)
            MIdle: if (sensorA) begin m_phase = MCollect; restart = 1; end
            MCollect: if (key_valid) begin
               if (key_code <= 4'd9 && m_digits.size() < 2) begin
                  m_digits.push_back(int'(key_code));
                  restart = 1;
               end else if (key_code == 4'hA && m_digits.size() > 0) begin
                  m_digits.delete();
                  restart = 1;
               end else if (key_code == 4'hB && m_digits.size() == 2) begin
                  m_phase = MSend;
                  restart = 1;
               end
            end
            MSend: begin
               m_pass  = m_digits[0] * 16 + m_digits[1];
               m_pv    = 1;
               m_att   = (m_att < 3) ? m_att + 1 : 3;
               m_phase = MResult;
               restart = 1;
            end
            MResult: begin
               if (gateState) begin
                  m_phase = MDone;
                  m_att = 0;
                  m_pass = 255;
                  restart = 1;
               end else if (wrongPinAlarm || m_age >= R) begin
                  m_phase = MCollect;
                  m_digits.delete();
                  m_pass = 255;
                  restart = 1;
               end
            end
            MDone: if (!sensorA) begin
               m_phase = MIdle;
               m_digits.delete();
               restart = 1;
            end
            default: ;
         endcase
      end
      m_age = restart ? 1 : m_age + 1;
   endfunction

   function automatic logic [13:0] expected();
      logic busy;
      busy = (m_phase == MCollect) || (m_phase == MSend) || (m_phase == MResult);
      return {8'(m_pass), m_pv, busy, 2'(m_digits.size()), 2'(m_att)};
   endfunction

   // ---------------- stimulus helpers (no checking) ----------------
   task automatic tick(input logic kv, input logic [3:0] kc);
      key_valid = kv;
      key_code  = kc;
      model_step();
      @(posedge clk);
      #1;
      key_valid = 1'b0;
   endtask

   // A few idle or ignored-key cycles, then the key itself.
   task automatic press(input logic [3:0] k);
      int gap;
      gap = $urandom_range(0, 3);
      for (int i = 0; i < gap; i++) tick(1'($urandom_range(0, 1)), 4'hC + 4'($urandom_range(0, 3)));
      tick(1'b1, k);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      model_reset();
      checks++;
      if (obs !== RESET_VEC) begin
         errors++; $display("FAIL reset_values obs=%h req=%h", obs, RESET_VEC);
      end
      rst_n = 1'b1;
      tick(1'b1, 4'h2);
      checks++;
      if (obs !== expected()) begin
         errors++; $display("FAIL reset_idle obs=%h req=%h", obs, expected());
      end
   endtask

   task automatic test_basic();
      sensorA = 1'b1;
      tick(1'b0, 4'h0);
      press(4'h2);
      press(4'h6);
      checks++;
      if (obs !== expected()) begin
         errors++; $display("FAIL basic_ready obs=%h req=%h", obs, expected());
      end
      press(4'hB);
      checks++;
      if (pass_valid !== 1'b0) begin
         errors++; $display("FAIL basic_send_early obs=%b req=0", pass_valid);
      end
      tick(1'b0, 4'h0);
      checks++;
      if ({pass_valid, pass, attempts} !== {1'b1, 8'h26, 2'd1}) begin
         errors++; $display("FAIL basic_pulse obs=%b/%h/%0d req=1/26/1", pass_valid, pass, attempts);
      end
      tick(1'b0, 4'h0);
      checks++;
      if (obs !== expected()) begin
         errors++; $display("FAIL basic_hold obs=%h req=%h", obs, expected());
      end
      gateState = 1'b1;
      tick(1'b0, 4'h0);
      gateState = 1'b0;
      checks++;
      if (obs !== expected() || entry_busy !== 1'b0 || pass !== 8'hFF) begin
         errors++; $display("FAIL basic_done obs=%h req=%h", obs, expected());
      end
      sensorA = 1'b0;
      tick(1'b0, 4'h0);
      checks++;
      if (obs !== expected()) begin
         errors++; $display("FAIL basic_exit obs=%h req=%h", obs, expected());
      end
   endtask

   task automatic test_clear();
      sensorA = 1'b1;
      tick(1'b0, 4'h0);
      press(4'h3);
      press(4'hA);
      checks++;
      if (digit_count !== 2'd0 || obs !== expected()) begin
         errors++; $display("FAIL clear_d2 obs=%h req=%h", obs, expected());
      end
      press(4'h2);
      press(4'h6);
      press(4'hB);
      tick(1'b0, 4'h0);
      checks++;
      if ({pass_valid, pass} !== {1'b1, 8'h26} || obs !== expected()) begin
         errors++; $display("FAIL clear_pulse obs=%h req=%h", obs, expected());
      end
      repeat (R) tick(1'b0, 4'h0);
      checks++;
      if (obs !== expected()) begin
         errors++; $display("FAIL clear_result_wait obs=%h req=%h", obs, expected());
      end
      sensorA = 1'b0;
      tick(1'b0, 4'h0);
   endtask

   task automatic test_timeout();
      bit saw_pv;
      saw_pv = 0;
      sensorA = 1'b1;
      tick(1'b0, 4'h0);
      press(4'h2);
      repeat (T - 1) begin
         tick(1'b0, 4'h0);
         saw_pv |= pass_valid;
      end
      checks++;
      if (digit_count !== 2'd1 || obs !== expected()) begin
         errors++; $display("FAIL timeout_early obs=%h req=%h", obs, expected());
      end
      tick(1'b0, 4'h0);
      checks++;
      if ({entry_busy, digit_count, saw_pv} !== {1'b1, 2'd0, 1'b0} || obs !== expected()) begin
         errors++; $display("FAIL timeout_d2 obs=%h req=%h", obs, expected());
      end
      press(4'h2);
      press(4'h6);
      repeat (T) tick(1'b0, 4'h0);
      checks++;
      if (digit_count !== 2'd0 || obs !== expected()) begin
         errors++; $display("FAIL timeout_ready obs=%h req=%h", obs, expected());
      end
      sensorA = 1'b0;
      tick(1'b0, 4'h0);
   endtask

   task automatic test_attempts();
      sensorA = 1'b1;
      tick(1'b0, 4'h0);
      for (int i = 0; i < 3; i++) begin
         press(4'h1);
         press(4'h1);
         press(4'hB);
         tick(1'b0, 4'h0);
         checks++;
         if ({pass_valid, pass, attempts} !== {1'b1, 8'h11, 2'(i + 1)}) begin
            errors++; $display("FAIL attempts_%0d obs=%b/%h/%0d req=1/11/%0d",
                               i, pass_valid, pass, attempts, i + 1);
         end
         if (i < 2) begin
            repeat (R) tick(1'b0, 4'h0);
         end else begin
            tick(1'b0, 4'h0);
            wrongPinAlarm = 1'b1;
            tick(1'b0, 4'h0);
            wrongPinAlarm = 1'b0;
         end
         checks++;
         if ({pass, digit_count, entry_busy} !== {8'hFF, 2'd0, 1'b1} || obs !== expected()) begin
            errors++; $display("FAIL attempts_rearm_%0d obs=%h req=%h", i, obs, expected());
         end
      end
      press(4'h2);
      press(4'h6);
      press(4'hB);
      tick(1'b0, 4'h0);
      checks++;
      if ({pass_valid, pass, attempts} !== {1'b1, 8'h26, 2'd3}) begin
         errors++; $display("FAIL attempts_recovery obs=%b/%h/%0d req=1/26/3",
                            pass_valid, pass, attempts);
      end
      gateState = 1'b1;
      wrongPinAlarm = 1'b1;
      tick(1'b0, 4'h0);
      gateState = 1'b0;
      wrongPinAlarm = 1'b0;
      checks++;
      if ({entry_busy, attempts} !== {1'b0, 2'd0} || obs !== expected()) begin
         errors++; $display("FAIL gate_wins obs=%h req=%h", obs, expected());
      end
      sensorA = 1'b0;
      tick(1'b0, 4'h0);
   endtask

   task automatic test_abort_reset();
      sensorA = 1'b1;
      tick(1'b0, 4'h0);
      press(4'h2);
      press(4'h6);
      sensorA = 1'b0;
      tick(1'b0, 4'h0);
      checks++;
      if (obs !== RESET_VEC || obs !== expected()) begin
         errors++; $display("FAIL abort_ready obs=%h req=%h", obs, RESET_VEC);
      end
      sensorA = 1'b1;
      tick(1'b0, 4'h0);
      press(4'h2);
      press(4'h6);
      press(4'hB);
      tick(1'b0, 4'h0);
      tick(1'b0, 4'h0);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (obs !== RESET_VEC) begin
         errors++; $display("FAIL async_reset obs=%h req=%h", obs, RESET_VEC);
      end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      tick(1'b0, 4'h0);
      checks++;
      if (obs !== expected()) begin
         errors++; $display("FAIL after_reset obs=%h req=%h", obs, expected());
      end
      sensorA = 1'b0;
      tick(1'b0, 4'h0);
   endtask

   task automatic test_ignored();
      logic [3:0] seq [14] = '{4'h7, 4'h0, 4'hC, 4'hF, 4'h2, 4'hD, 4'h6, 4'h5, 4'hB, 4'h3,
                               4'hA, 4'hE, 4'h9, 4'hB};
      sensorA = 1'b0;
      tick(1'b1, 4'h4);
      checks++;
      if (obs !== expected()) begin
         errors++; $display("FAIL ignored_idle obs=%h req=%h", obs, expected());
      end
      sensorA = 1'b1;
      for (int i = 0; i < 14; i++) begin
         gateState = (i == 12);
         tick(1'b1, seq[i]);
         checks++;
         if (obs !== expected()) begin
            errors++; $display("FAIL ignored_step%0d obs=%h req=%h", i, obs, expected());
         end
      end
      gateState = 1'b0;
      sensorA = 1'b0;
      tick(1'b0, 4'h0);
   endtask

   task automatic test_random();
      int r;
      for (int c = 0; c < 3000; c++) begin
         sensorA       = ($urandom_range(0, 39) != 0);
         gateState     = ($urandom_range(0, 11) == 0);
         wrongPinAlarm = ($urandom_range(0, 7) == 0);
         r = $urandom_range(0, 9);
         if (r < 6)       tick(1'($urandom_range(0, 1)), 4'($urandom_range(0, 9)));
         else if (r < 8)  tick(1'b1, 4'hB);
         else if (r == 8) tick(1'b1, 4'hA);
         else             tick(1'b1, 4'hC + 4'($urandom_range(0, 3)));
         checks++;
         if (obs !== expected()) begin
            errors++; $display("FAIL random_cyc%0d obs=%h req=%h", c, obs, expected());
         end
      end
      gateState = 1'b0;
      wrongPinAlarm = 1'b0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_basic();
      test_clear();
      test_timeout();
      test_attempts();
      test_abort_reset();
      test_ignored();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog obs=running req=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
